// File: rtl/icache_if.sv
// Fetch-side and memory-refill signal bundle for the instruction cache.
interface icache_if;
    logic        rdy;
    logic        fetch_enable;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic        fetch_success;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_word;
    logic        mem_valid;

    modport slave (
        input  rdy, fetch_enable, fetch_pc, flush, mem_word, mem_valid,
        output fetch_instr, fetch_success, mem_req, mem_addr
    );

    modport master (
        output rdy, fetch_enable, fetch_pc, flush, mem_word, mem_valid,
        input  fetch_instr, fetch_success, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Define ICACHE_STAT_EN to add hit/miss counter outputs.
//
// state     | meaning
// S_IDLE    | accept a fetch; hits answer next cycle, misses start a refill
// S_REFILL  | collect one word per mem_valid until the line is full
// S_RESPOND | report the requested word unless the request was flushed
module icache #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2
) (
    input  logic    clk,
    input  logic    rst,
    icache_if.slave bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int LINE_LSB = OFFSET_BITS + 2;
    localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
    localparam int TAG_BITS = 32 - TAG_LSB;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REFILL  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]             r_state;
    logic [LINES-1:0]       r_valid;
    logic [TAG_BITS-1:0]    r_tag  [0:LINES-1];
    logic [31:0]            r_data [0:LINES*WORDS-1];

    logic [TAG_BITS-1:0]    r_req_tag;
    logic [INDEX_BITS-1:0]  r_req_idx;
    logic [OFFSET_BITS-1:0] r_req_off;
    logic [OFFSET_BITS-1:0] r_cnt;
    logic                   r_drop;
    logic                   r_success;
    logic [31:0]            r_instr;
    logic                   r_mem_req;
    logic [31:0]            r_mem_addr;

    logic [OFFSET_BITS-1:0] w_pc_off;
    logic [INDEX_BITS-1:0]  w_pc_idx;
    logic [TAG_BITS-1:0]    w_pc_tag;
    logic                   w_hit;
    logic                   w_accept;
    logic                   w_beat;
    logic                   w_last;
    logic [31:0]            w_hit_word;
    logic [31:0]            w_resp_word;
    logic                   w_unused_pc_lsb;

    assign w_pc_off        = bus.fetch_pc[LINE_LSB-1:2];
    assign w_pc_idx        = bus.fetch_pc[TAG_LSB-1:LINE_LSB];
    assign w_pc_tag        = bus.fetch_pc[31:TAG_LSB];
    assign w_unused_pc_lsb = ^bus.fetch_pc[1:0];

    assign w_hit       = r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);
    assign w_hit_word  = r_data[{w_pc_idx, w_pc_off}];
    assign w_resp_word = r_data[{r_req_idx, r_req_off}];

    assign w_accept = (r_state == S_IDLE) && bus.fetch_enable && !bus.flush;
    assign w_beat   = (r_state == S_REFILL) && bus.mem_valid;
    assign w_last   = w_beat && (r_cnt == OFFSET_BITS'(WORDS - 1));

    assign bus.fetch_success = r_success;
    assign bus.fetch_instr   = r_instr;
    assign bus.mem_req       = r_mem_req;
    assign bus.mem_addr      = r_mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_req_tag  <= '0;
            r_req_idx  <= '0;
            r_req_off  <= '0;
            r_cnt      <= '0;
            r_drop     <= 1'b0;
            r_success  <= 1'b0;
            r_instr    <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else if (bus.rdy) begin
            r_success <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_tag <= w_pc_tag;
                        r_req_idx <= w_pc_idx;
                        r_req_off <= w_pc_off;
                        if (w_hit) begin
                            r_success <= 1'b1;
                            r_instr   <= w_hit_word;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {bus.fetch_pc[31:LINE_LSB], {LINE_LSB{1'b0}}};
                            r_cnt      <= '0;
                            r_drop     <= 1'b0;
                            r_state    <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    // The memory handshake cannot be aborted, so a flush only marks the answer as stale.
                    if (bus.flush) begin
                        r_drop <= 1'b1;
                    end
                    if (w_beat) begin
                        r_cnt      <= r_cnt + OFFSET_BITS'(1);
                        r_mem_addr <= r_mem_addr + 32'd4;
                    end
                    if (w_last) begin
                        r_valid[r_req_idx] <= 1'b1;
                        r_mem_req          <= 1'b0;
                        r_state            <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (!r_drop && !bus.flush) begin
                        r_success <= 1'b1;
                        r_instr   <= w_resp_word;
                    end
                    r_drop  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && w_beat) begin
            r_data[{r_req_idx, r_cnt}] <= bus.mem_word;
            if (w_last) begin
                r_tag[r_req_idx] <= r_req_tag;
            end
        end
    end

`ifdef ICACHE_STAT_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (bus.rdy && w_accept) begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;
`endif

endmodule
